// File: rtl/if_stage.sv
// if_stage: RV64 instruction fetch, one outstanding imem read.
// Owns the fetch PC, feeds {inst, pc} to decode via valid/ready.
//
// Ports:
//   clk, rst               core clock, sync active-high reset
//   imem_req_valid/ready   read request handshake
//   imem_req_addr          8-byte aligned read address
//   imem_resp_valid/data   read response (one per accepted req)
//   redirect_valid/pc      control-flow redirect from EXE
//   id_valid/ready         decode handshake
//   id_inst, id_pc         fetched instruction and its address
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc
);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        drop;

  logic        req_fire;
  logic        id_fire;
  logic        unused_redir;

  // Only issue when the output buffer is empty or draining,
  // so a landing response can never overflow it.
  assign imem_req_valid = !rst
                       && (state == S_REQ)
                       && !redirect_valid
                       && (!id_valid || id_ready);

  assign imem_req_addr = {pc[63:3], 3'b000};
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign id_fire       = id_valid && id_ready;
  assign unused_redir  = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= S_REQ;
      drop     <= 1'b0;
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= 64'h0;
    end else begin
      if (id_fire) begin
        id_valid <= 1'b0;
      end

      if (redirect_valid) begin
        pc       <= {redirect_pc[63:2], 2'b00};
        id_valid <= 1'b0;
        if (state == S_WAIT) begin
          // A response this cycle is the stale one: consume it now.
          if (imem_resp_valid) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else begin
            drop <= 1'b1;
          end
        end
      end else begin
        unique case (state)
          S_REQ: begin
            if (req_fire) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              state <= S_REQ;
              if (drop) begin
                drop <= 1'b0;
              end else begin
                id_inst  <= pc[2] ? imem_resp_data[63:32]
                                  : imem_resp_data[31:0];
                id_pc    <= pc;
                id_valid <= 1'b1;
                pc       <= pc + 64'd4;
              end
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: cycle-table directed bench for if_stage.
// Each row drives inputs for one cycle and checks outputs.
module tb_if_stage;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] D0  = 64'h0010_0093_0000_0013;
  localparam logic [63:0] D1  = 64'h0000_0517_0020_0113;
  localparam logic [63:0] D2  = 64'hDEAD_BEEF_0040_0193;
  localparam logic [63:0] D3  = 64'h1111_1111_2222_2222;
  localparam logic [63:0] D4  = 64'hCAFE_F00D_0000_0073;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;

  int passed;
  int total;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        rv;
    logic [63:0] rd;
    logic        xv;
    logic [63:0] xp;
    logic        ir;
    logic        e_rq;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input logic rr, input logic rv, input logic [63:0] rd,
    input logic xv, input logic [63:0] xp, input logic ir,
    input logic e_rq, input logic [63:0] e_addr,
    input logic e_iv, input logic [31:0] e_inst,
    input logic [63:0] e_pc
  );
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd;
    v.xv = xv; v.xp = xp; v.ir = ir;
    v.e_rq = e_rq; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic ok,
                     input string got, input string want);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %s want %s", name, got, want);
  endtask

  task automatic chk_outs(input string name,
    input logic e_rq, input logic [63:0] e_addr,
    input logic e_iv, input logic [31:0] e_inst,
    input logic [63:0] e_pc);
    logic ok;
    ok = (imem_req_valid === e_rq) && (imem_req_addr === e_addr)
      && (id_valid === e_iv) && (id_inst === e_inst)
      && (id_pc === e_pc);
    chk(name, ok,
      $sformatf("rq=%b addr=%h iv=%b inst=%h pc=%h",
        imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc),
      $sformatf("rq=%b addr=%h iv=%b inst=%h pc=%h",
        e_rq, e_addr, e_iv, e_inst, e_pc));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 64'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    id_ready        = 1'b0;

    // A: zero-latency fetch of two words at RESET_PC
    add(1,0,0, 0,0, 1,  1,RPC,          0,32'h0,        64'h0);
    add(0,1,D0,0,0, 1,  0,RPC,          0,32'h0,        64'h0);
    add(1,0,0, 0,0, 1,  1,RPC,          1,32'h00000013, RPC);
    add(0,1,D0,0,0, 1,  0,RPC,          0,32'h00000013, RPC);
    // B: decode stalls 5 cycles, buffer holds, no request
    for (int i = 0; i < 5; i++)
      add(1,0,0,0,0,0,  0,64'h80000008, 1,32'h00100093, 64'h80000004);
    add(1,0,0, 0,0, 1,  1,64'h80000008, 1,32'h00100093, 64'h80000004);
    add(0,1,D1,0,0, 1,  0,64'h80000008, 0,32'h00100093, 64'h80000004);
    // C: memory not ready for 3 cycles, then one accept
    add(0,0,0, 0,0, 1,  1,64'h80000008, 1,32'h00200113, 64'h80000008);
    add(0,0,0, 0,0, 1,  1,64'h80000008, 0,32'h00200113, 64'h80000008);
    add(0,0,0, 0,0, 1,  1,64'h80000008, 0,32'h00200113, 64'h80000008);
    add(1,0,0, 0,0, 1,  1,64'h80000008, 0,32'h00200113, 64'h80000008);
    add(1,0,0, 0,0, 1,  0,64'h80000008, 0,32'h00200113, 64'h80000008);
    add(0,1,D1,0,0, 1,  0,64'h80000008, 0,32'h00200113, 64'h80000008);
    // D: redirect in S_WAIT, stale response 2 cycles later
    add(1,0,0, 0,0, 1,  1,64'h80000010, 1,32'h00000517, 64'h8000000C);
    add(1,0,0, 1,64'h80001002, 1,
                        0,64'h80000010, 0,32'h00000517, 64'h8000000C);
    add(1,0,0, 0,0, 1,  0,64'h80001000, 0,32'h00000517, 64'h8000000C);
    add(1,1,D0,0,0, 1,  0,64'h80001000, 0,32'h00000517, 64'h8000000C);
    add(1,0,0, 0,0, 1,  1,64'h80001000, 0,32'h00000517, 64'h8000000C);
    add(0,1,D2,0,0, 1,  0,64'h80001000, 0,32'h00000517, 64'h8000000C);
    // E: redirect in the same cycle as the response
    add(1,0,0, 0,0, 1,  1,64'h80001000, 1,32'h00400193, 64'h80001000);
    add(1,1,D2,1,64'h80002000, 1,
                        0,64'h80001000, 0,32'h00400193, 64'h80001000);
    add(1,0,0, 0,0, 1,  1,64'h80002000, 0,32'h00400193, 64'h80001000);
    add(0,1,D3,0,0, 1,  0,64'h80002000, 0,32'h00400193, 64'h80001000);
    // F: redirect in the same cycle as a decode handshake
    add(1,0,0, 1,64'h80003004, 1,
                        0,64'h80002000, 1,32'h22222222, 64'h80002000);
    add(1,0,0, 0,0, 1,  1,64'h80003000, 0,32'h22222222, 64'h80002000);
    add(0,1,D3,0,0, 1,  0,64'h80003000, 0,32'h22222222, 64'h80002000);
    // G: back-to-back redirects while dropping, then PC wrap
    add(1,0,0, 0,0, 1,  1,64'h80003008, 1,32'h11111111, 64'h80003004);
    add(1,0,0, 1,64'h80004000, 1,
                        0,64'h80003008, 0,32'h11111111, 64'h80003004);
    add(1,0,0, 1,64'hFFFFFFFFFFFFFFFF, 1,
                        0,64'h80004000, 0,32'h11111111, 64'h80003004);
    add(1,1,D0,0,0, 1,  0,64'hFFFFFFFFFFFFFFF8,
                          0,32'h11111111, 64'h80003004);
    add(1,0,0, 0,0, 1,  1,64'hFFFFFFFFFFFFFFF8,
                          0,32'h11111111, 64'h80003004);
    add(0,1,D4,0,0, 1,  0,64'hFFFFFFFFFFFFFFF8,
                          0,32'h11111111, 64'h80003004);
    add(1,0,0, 0,0, 1,  1,64'h0,
                          1,32'hCAFEF00D, 64'hFFFFFFFFFFFFFFFC);
    add(1,0,0, 0,0, 1,  0,64'h0,
                          0,32'hCAFEF00D, 64'hFFFFFFFFFFFFFFFC);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_outs("reset", 1'b0, RPC, 1'b0, 32'h0, 64'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst             = 1'b0;
      imem_req_ready  = vecs[i].rr;
      imem_resp_valid = vecs[i].rv;
      imem_resp_data  = vecs[i].rd;
      redirect_valid  = vecs[i].xv;
      redirect_pc     = vecs[i].xp;
      id_ready        = vecs[i].ir;
      #1;
      chk_outs($sformatf("row%0d", i), vecs[i].e_rq, vecs[i].e_addr,
               vecs[i].e_iv, vecs[i].e_inst, vecs[i].e_pc);
    end

    // Reset asserted mid-fetch, then a stale response in S_REQ
    @(negedge clk);
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    id_ready        = 1'b1;
    #1;
    chk("rst_no_req", imem_req_valid === 1'b0,
        $sformatf("%b", imem_req_valid), "0");
    @(negedge clk);
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = D0;
    #1;
    chk_outs("rst_mid", 1'b1, RPC, 1'b0, 32'h0, 64'h0);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    chk_outs("stale_ign", 1'b1, RPC, 1'b0, 32'h0, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage for the RV64 core. It owns the fetch PC and issues one outstanding 64-bit instruction-memory read at a time. It selects the 32-bit instruction word and presents `{inst, pc}` to the decode stage over a valid/ready handshake. It accepts redirects from branch/jump resolution and discards any fetch already in flight when a redirect arrives.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 64: read address, 8-byte aligned (`{pc[63:3],3'b0}`).
- `imem_resp_valid` in 1: read data valid; one response per accepted request, at least one cycle after acceptance.
- `imem_resp_data` in 64: read doubleword.
- `redirect_valid` in 1: control-flow redirect from EXE.
- `redirect_pc` in 64: redirect target; bits [1:0] ignored.
- `id_valid` out 1: `id_inst`/`id_pc` valid.
- `id_ready` in 1: decode stage accepts this cycle.
- `id_inst` out 32: fetched instruction.
- `id_pc` out 64: address of `id_inst`.

## Operation
- State registers: `pc` (64), `state` ∈ {S_REQ, S_WAIT}, `drop` (1), output buffer {`id_valid`, `id_inst`, `id_pc`}.
- S_REQ:
  - `imem_req_valid = !redirect_valid && (!id_valid || id_ready)`.
  - On `imem_req_valid && imem_req_ready`, go to S_WAIT.
  - `imem_req_addr` may change while the request is not yet accepted; memory samples it only on handshake.
  - `imem_resp_valid` seen in S_REQ is ignored.
- S_WAIT:
  - `imem_req_valid = 0`.
  - On `imem_resp_valid` with `drop=0` and no `redirect_valid`:
    - `id_inst <= pc[2] ? data[63:32] : data[31:0]`.
    - `id_pc <= pc`, `id_valid <= 1`.
    - `pc <= pc + 4`, wrapping modulo 2^64.
    - Go to S_REQ.
  - On `imem_resp_valid` with `drop=1`: discard the data, `drop <= 0`, go to S_REQ.
- Output buffer: `id_valid` clears on `id_valid && id_ready` unless reloaded in the same cycle.
  - Single outstanding request plus the issue condition guarantee the buffer is empty or draining whenever a response lands. No overflow case exists.
- Redirect (`redirect_valid=1`), any state, highest priority:
  - `pc <= {redirect_pc[63:2], 2'b00}`.
  - `id_valid <= 0` (flush). The flush wins over a same-cycle `id_ready` handshake. `id_inst`/`id_pc` keep their values.
  - In S_WAIT without `imem_resp_valid`: `drop <= 1`, stay in S_WAIT.
  - In S_WAIT with `imem_resp_valid`: discard the response, `drop <= 0`, go to S_REQ.
  - In S_REQ: no request is issued this cycle; next cycle requests the new `pc`.
  - Repeated redirects while `drop=1`: the latest target wins; `drop` stays 1 until the stale response arrives.
- Throughput: at best one instruction every 2 cycles (request cycle plus response cycle, with zero-latency memory).

## Timing
- Reset values:
  - `pc = RESET_PC`, `state = S_REQ`, `drop = 0`.
  - `id_valid = 0`, `id_inst = 32'h0`, `id_pc = 64'h0`.
  - `imem_req_valid = 0` while `rst` is high.
- First request: `imem_req_valid=1` with addr `RESET_PC` in the first cycle after `rst` deasserts.
- Latency: response capture happens at the clock edge of the `imem_resp_valid` cycle. `id_valid` is high the next cycle.
- Reset asserted mid-fetch: all state returns to reset values. A later stale `imem_resp_valid` is ignored because the block is in S_REQ. The memory side is reset together with the core.
- `id_inst`, `id_pc` and `id_valid` are registered. `imem_req_valid` is combinational from state, `id_valid`, `id_ready` and `redirect_valid`. `imem_req_addr` is combinational from `pc`.

## Test plan
- Reset, zero-latency memory (ready=1, resp next cycle), `id_ready=1`, data = 64'h0010_0093_0000_0013 at 0x80000000:
  - Expect `id_inst=0x00000013` with `id_pc=0x80000000`.
  - Then a request at addr 0x80000000 again (pc=0x80000004).
  - Then `id_inst=0x00100093` with `id_pc=0x80000004`.
  - Then a request at 0x80000008.
- `id_ready=0` held 5 cycles after the first instruction: `id_valid`, `id_inst` and `id_pc` stay stable, and no new `imem_req_valid` is issued. After release, the next request issues in the same cycle as the handshake.
- `imem_req_ready=0` for 3 cycles: `imem_req_valid` stays high with a constant address. Exactly one request is accepted when ready rises.
- Redirect to 0x80001002 during S_WAIT, with the response arriving 2 cycles later:
  - The stale response is dropped and `id_valid` stays 0.
  - The next request addr is 0x80001000 (pc=0x80001000).
  - The captured instruction is `data[31:0]` with `id_pc=0x80001000`.
- Redirect in the same cycle as `imem_resp_valid`, and separately in the same cycle as an `id_ready` handshake: the response is discarded, `id_valid=0` next cycle, and the next request targets the redirect.
- Start with `pc=0xFFFF_FFFF_FFFF_FFFC` (via redirect): `id_inst=data[63:32]`, and the following request addr is 0x0 (wrap).
